// File: rtl/mult_rs.sv
// Reservation station in front of the multiply FU: holds dispatched ops until both source
// values are known (directly or snooped from the CDB), then issues them one at a time.
module mult_rs #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [7:0]                 disp_operand,
    input  logic [1:0]                 disp_src_rdy,
    input  logic [1:0][TAG_W-1:0]      disp_src_tag,
    input  logic [1:0][DATA_W-1:0]     disp_src_val,
    input  logic [7:0]                 disp_wbs,
    input  logic [7:0]                 disp_flags,
    input  logic [TAG_W-1:0]           disp_robid,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_id,
    input  logic [DATA_W-1:0]          cdb_val,
    input  logic                       flush,
    input  logic                       fu_busy,
    output logic                       issue_transmit,
    output logic [7:0]                 issue_operand,
    output logic [1:0][DATA_W-1:0]     issue_depvals,
    output logic [7:0]                 issue_wbs,
    output logic [7:0]                 issue_flags,
    output logic [TAG_W-1:0]           issue_robid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                   valid_q   [DEPTH];
    logic                   valid_d   [DEPTH];
    logic [7:0]             operand_q [DEPTH];
    logic [7:0]             operand_d [DEPTH];
    logic [7:0]             wbs_q     [DEPTH];
    logic [7:0]             wbs_d     [DEPTH];
    logic [7:0]             flags_q   [DEPTH];
    logic [7:0]             flags_d   [DEPTH];
    logic [TAG_W-1:0]       robid_q   [DEPTH];
    logic [TAG_W-1:0]       robid_d   [DEPTH];
    logic [1:0]             rdy_q     [DEPTH];
    logic [1:0]             rdy_d     [DEPTH];
    logic [1:0][TAG_W-1:0]  tag_q     [DEPTH];
    logic [1:0][TAG_W-1:0]  tag_d     [DEPTH];
    logic [1:0][DATA_W-1:0] val_q     [DEPTH];
    logic [1:0][DATA_W-1:0] val_d     [DEPTH];

    logic [OCC_W-1:0]       occ_q, occ_d;

    logic                   tx_q, tx_d;
    logic [7:0]             iss_operand_q, iss_operand_d;
    logic [1:0][DATA_W-1:0] iss_depvals_q, iss_depvals_d;
    logic [7:0]             iss_wbs_q, iss_wbs_d;
    logic [7:0]             iss_flags_q, iss_flags_d;
    logic [TAG_W-1:0]       iss_robid_q, iss_robid_d;

    logic [IDX_W-1:0]       free_idx, sel_idx;
    logic                   sel_found;
    logic                   do_disp, do_issue;

    assign dispatch_ready = (occ_q != OCC_W'(DEPTH));
    assign do_disp        = dispatch_valid && dispatch_ready;
    // The cycle after an issue is a holdoff so the FU has time to raise busy.
    assign do_issue       = sel_found && !fu_busy && !tx_q;

    // Lowest-index free slot and lowest-index ready entry (registered readiness only).
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
            if (valid_q[i] && (&rdy_q[i])) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        operand_d     = operand_q;
        wbs_d         = wbs_q;
        flags_d       = flags_q;
        robid_d       = robid_q;
        rdy_d         = rdy_q;
        tag_d         = tag_q;
        val_d         = val_q;
        occ_d         = occ_q;
        tx_d          = 1'b0;
        iss_operand_d = iss_operand_q;
        iss_depvals_d = iss_depvals_q;
        iss_wbs_d     = iss_wbs_q;
        iss_flags_d   = iss_flags_q;
        iss_robid_d   = iss_robid_q;

        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_d[i] = 1'b0;
            end
            occ_d = '0;
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    for (int s = 0; s < 2; s++) begin
                        if (valid_q[i] && !rdy_q[i][s] && (tag_q[i][s] == cdb_id)) begin
                            rdy_d[i][s] = 1'b1;
                            val_d[i][s] = cdb_val;
                        end
                    end
                end
            end

            if (do_issue) begin
                valid_d[sel_idx] = 1'b0;
                tx_d             = 1'b1;
                iss_operand_d    = operand_q[sel_idx];
                iss_depvals_d    = val_q[sel_idx];
                iss_wbs_d        = wbs_q[sel_idx];
                iss_flags_d      = flags_q[sel_idx];
                iss_robid_d      = robid_q[sel_idx];
            end

            if (do_disp) begin
                valid_d[free_idx]   = 1'b1;
                operand_d[free_idx] = disp_operand;
                wbs_d[free_idx]     = disp_wbs;
                flags_d[free_idx]   = disp_flags;
                robid_d[free_idx]   = disp_robid;
                for (int s = 0; s < 2; s++) begin
                    tag_d[free_idx][s] = disp_src_tag[s];
                    // A broadcast in the dispatch cycle would otherwise be missed.
                    if (disp_src_rdy[s]) begin
                        rdy_d[free_idx][s] = 1'b1;
                        val_d[free_idx][s] = disp_src_val[s];
                    end else if (cdb_valid && (cdb_id == disp_src_tag[s])) begin
                        rdy_d[free_idx][s] = 1'b1;
                        val_d[free_idx][s] = cdb_val;
                    end else begin
                        rdy_d[free_idx][s] = 1'b0;
                        val_d[free_idx][s] = disp_src_val[s];
                    end
                end
            end

            unique case ({do_disp, do_issue})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_q[i]   <= 1'b0;
                operand_q[i] <= '0;
                wbs_q[i]     <= '0;
                flags_q[i]   <= '0;
                robid_q[i]   <= '0;
                rdy_q[i]     <= '0;
                tag_q[i]     <= '0;
                val_q[i]     <= '0;
            end
            occ_q         <= '0;
            tx_q          <= 1'b0;
            iss_operand_q <= '0;
            iss_depvals_q <= '0;
            iss_wbs_q     <= '0;
            iss_flags_q   <= '0;
            iss_robid_q   <= '0;
        end else begin
            valid_q       <= valid_d;
            operand_q     <= operand_d;
            wbs_q         <= wbs_d;
            flags_q       <= flags_d;
            robid_q       <= robid_d;
            rdy_q         <= rdy_d;
            tag_q         <= tag_d;
            val_q         <= val_d;
            occ_q         <= occ_d;
            tx_q          <= tx_d;
            iss_operand_q <= iss_operand_d;
            iss_depvals_q <= iss_depvals_d;
            iss_wbs_q     <= iss_wbs_d;
            iss_flags_q   <= iss_flags_d;
            iss_robid_q   <= iss_robid_d;
        end
    end

    assign issue_transmit = tx_q;
    assign issue_operand  = iss_operand_q;
    assign issue_depvals  = iss_depvals_q;
    assign issue_wbs      = iss_wbs_q;
    assign issue_flags    = iss_flags_q;
    assign issue_robid    = iss_robid_q;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_mult_rs.sv
// Directed bench for mult_rs: a behavioural entry-list model checked every cycle, plus
// hand-computed expectations at the key cycles of each scenario.
module tb_mult_rs;

    logic            clk = 1'b0;
    logic            rst;
    logic            dispatch_valid = 1'b0;
    logic            dispatch_ready;
    logic [7:0]      disp_operand = '0;
    logic [1:0]      disp_src_rdy = '0;
    logic [1:0][3:0] disp_src_tag = '0;
    logic [1:0][7:0] disp_src_val = '0;
    logic [7:0]      disp_wbs = '0;
    logic [7:0]      disp_flags = '0;
    logic [3:0]      disp_robid = '0;
    logic            cdb_valid = 1'b0;
    logic [3:0]      cdb_id = '0;
    logic [7:0]      cdb_val = '0;
    logic            flush = 1'b0;
    logic            fu_busy = 1'b0;
    logic            issue_transmit;
    logic [7:0]      issue_operand;
    logic [1:0][7:0] issue_depvals;
    logic [7:0]      issue_wbs;
    logic [7:0]      issue_flags;
    logic [3:0]      issue_robid;
    logic [2:0]      occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    mult_rs #(.DEPTH(4), .TAG_W(4), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .disp_operand   (disp_operand),
        .disp_src_rdy   (disp_src_rdy),
        .disp_src_tag   (disp_src_tag),
        .disp_src_val   (disp_src_val),
        .disp_wbs       (disp_wbs),
        .disp_flags     (disp_flags),
        .disp_robid     (disp_robid),
        .cdb_valid      (cdb_valid),
        .cdb_id         (cdb_id),
        .cdb_val        (cdb_val),
        .flush          (flush),
        .fu_busy        (fu_busy),
        .issue_transmit (issue_transmit),
        .issue_operand  (issue_operand),
        .issue_depvals  (issue_depvals),
        .issue_wbs      (issue_wbs),
        .issue_flags    (issue_flags),
        .issue_robid    (issue_robid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: an unordered list of slots, scanned from index 0.
    typedef struct packed {
        logic            v;
        logic [7:0]      op;
        logic [7:0]      wbs;
        logic [7:0]      flg;
        logic [3:0]      rob;
        logic [1:0]      rdy;
        logic [1:0][3:0] tag;
        logic [1:0][7:0] val;
    } ent_t;

    ent_t            m_e [4];
    logic            m_tx;
    logic [7:0]      m_op, m_wbs, m_flg;
    logic [1:0][7:0] m_dep;
    logic [3:0]      m_rob;
    int              m_sel, m_fr;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) if (m_e[i].v) c++;
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_e[i] = '0;
            m_tx = 0; m_op = 0; m_wbs = 0; m_flg = 0; m_dep = '0; m_rob = 0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) m_e[i].v = 1'b0;
            m_tx = 0;
        end else begin
            m_sel = -1;
            m_fr  = -1;
            for (int i = 3; i >= 0; i--) begin
                if (m_e[i].v && m_e[i].rdy == 2'b11) m_sel = i;
                if (!m_e[i].v) m_fr = i;
            end
            if (cdb_valid)
                for (int i = 0; i < 4; i++)
                    for (int s = 0; s < 2; s++)
                        if (m_e[i].v && !m_e[i].rdy[s] && m_e[i].tag[s] == cdb_id) begin
                            m_e[i].rdy[s] = 1'b1;
                            m_e[i].val[s] = cdb_val;
                        end
            if (m_sel >= 0 && !fu_busy && !m_tx) begin
                m_tx = 1;
                m_op = m_e[m_sel].op; m_wbs = m_e[m_sel].wbs; m_flg = m_e[m_sel].flg;
                m_dep = m_e[m_sel].val; m_rob = m_e[m_sel].rob;
                m_e[m_sel].v = 1'b0;
            end else begin
                m_tx = 0;
            end
            if (dispatch_valid && m_fr >= 0) begin
                m_e[m_fr].v   = 1'b1;
                m_e[m_fr].op  = disp_operand;
                m_e[m_fr].wbs = disp_wbs;
                m_e[m_fr].flg = disp_flags;
                m_e[m_fr].rob = disp_robid;
                m_e[m_fr].tag = disp_src_tag;
                m_e[m_fr].rdy = disp_src_rdy;
                m_e[m_fr].val = disp_src_val;
                for (int s = 0; s < 2; s++)
                    if (!disp_src_rdy[s] && cdb_valid && cdb_id == disp_src_tag[s]) begin
                        m_e[m_fr].rdy[s] = 1'b1;
                        m_e[m_fr].val[s] = cdb_val;
                    end
            end
        end
    end

    always @(negedge clk) begin
        check("m_transmit", int'(issue_transmit), int'(m_tx));
        check("m_operand", int'(issue_operand), int'(m_op));
        check("m_depval0", int'(issue_depvals[0]), int'(m_dep[0]));
        check("m_depval1", int'(issue_depvals[1]), int'(m_dep[1]));
        check("m_wbs", int'(issue_wbs), int'(m_wbs));
        check("m_flags", int'(issue_flags), int'(m_flg));
        check("m_robid", int'(issue_robid), int'(m_rob));
        check("m_occupancy", int'(occupancy), m_count());
        check("m_dispatch_ready", int'(dispatch_ready), int'(m_count() != 4));
    end

    task automatic tick();
        @(negedge clk);
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic set_disp(input logic [7:0] op, input logic [1:0] rdy, input logic [3:0] t0,
                            input logic [3:0] t1, input logic [7:0] v0, input logic [7:0] v1,
                            input logic [3:0] rob);
        dispatch_valid  = 1'b1;
        disp_operand    = op;
        disp_src_rdy    = rdy;
        disp_src_tag[0] = t0;
        disp_src_tag[1] = t1;
        disp_src_val[0] = v0;
        disp_src_val[1] = v1;
        disp_wbs        = op + 8'd1;
        disp_flags      = {4'h8, rob};
        disp_robid      = rob;
    endtask

    task automatic set_cdb(input logic [3:0] id, input logic [7:0] v);
        cdb_valid = 1'b1;
        cdb_id    = id;
        cdb_val   = v;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_transmit", int'(issue_transmit), 0);
        check("reset_occupancy", int'(occupancy), 0);
        check("reset_ready", int'(dispatch_ready), 1);
        rst = 1'b1;
        tick();

        // Both sources ready: issue two cycles after dispatch.
        set_disp(8'h01, 2'b11, 4'h0, 4'h0, 8'h03, 8'h05, 4'h2);
        tick();
        check("t1_occ_c1", int'(occupancy), 1);
        check("t1_tx_c1", int'(issue_transmit), 0);
        tick();
        check("t1_tx_c2", int'(issue_transmit), 1);
        check("t1_dep0", int'(issue_depvals[0]), 3);
        check("t1_dep1", int'(issue_depvals[1]), 5);
        check("t1_robid", int'(issue_robid), 2);
        check("t1_flags", int'(issue_flags), 'h82);
        tick();
        check("t1_tx_c3", int'(issue_transmit), 0);
        check("t1_occ_c3", int'(occupancy), 0);

        // Wakeup via CDB; a non-matching tag does nothing.
        set_disp(8'h02, 2'b10, 4'h5, 4'h0, 8'h00, 8'h07, 4'h3);
        tick();
        tick();
        set_cdb(4'h6, 8'h99);
        tick();
        check("t2_tx_c3", int'(issue_transmit), 0);
        set_cdb(4'h5, 8'h2A);
        tick();
        check("t2_tx_c4", int'(issue_transmit), 0);
        tick();
        check("t2_tx_c5", int'(issue_transmit), 1);
        check("t2_dep0", int'(issue_depvals[0]), 'h2A);
        check("t2_dep1", int'(issue_depvals[1]), 7);
        tick();

        // Dispatch-cycle bypass from the CDB.
        set_disp(8'h03, 2'b10, 4'h9, 4'h0, 8'h00, 8'h22, 4'h4);
        set_cdb(4'h9, 8'h11);
        tick();
        tick();
        check("t3_tx", int'(issue_transmit), 1);
        check("t3_dep0", int'(issue_depvals[0]), 'h11);
        check("t3_dep1", int'(issue_depvals[1]), 'h22);
        tick();

        // Fill, reject a fifth dispatch, wake entries 1 and 3 with one shared tag.
        set_disp(8'h10, 2'b10, 4'h1, 4'h0, 8'h00, 8'h01, 4'h8);
        tick();
        set_disp(8'h11, 2'b10, 4'h7, 4'h0, 8'h00, 8'h02, 4'h9);
        tick();
        set_disp(8'h12, 2'b10, 4'h3, 4'h0, 8'h00, 8'h03, 4'hA);
        tick();
        set_disp(8'h13, 2'b10, 4'h7, 4'h0, 8'h00, 8'h04, 4'hB);
        tick();
        check("t4_occ_full", int'(occupancy), 4);
        check("t4_ready_full", int'(dispatch_ready), 0);
        set_disp(8'h14, 2'b11, 4'h0, 4'h0, 8'hEE, 8'hEE, 4'hF);
        tick();
        check("t4_occ_after_5th", int'(occupancy), 4);
        set_cdb(4'h7, 8'h55);
        tick();
        check("t4_tx_w1", int'(issue_transmit), 0);
        tick();
        check("t4_tx_w2", int'(issue_transmit), 1);
        check("t4_rob_first", int'(issue_robid), 9);
        check("t4_dep_first", int'(issue_depvals[0]), 'h55);
        tick();
        check("t4_tx_holdoff", int'(issue_transmit), 0);
        tick();
        check("t4_tx_second", int'(issue_transmit), 1);
        check("t4_rob_second", int'(issue_robid), 'hB);
        check("t4_dep1_second", int'(issue_depvals[1]), 4);
        set_disp(8'h15, 2'b10, 4'hE, 4'h0, 8'h00, 8'h05, 4'hC);
        tick();
        check("t4_occ_three", int'(occupancy), 3);

        // Flush wins over a wakeup in the same cycle; issue data is retained.
        flush = 1'b1;
        set_cdb(4'h1, 8'h66);
        tick();
        check("t5_occ_flush", int'(occupancy), 0);
        check("t5_ready_flush", int'(dispatch_ready), 1);
        check("t5_rob_kept", int'(issue_robid), 'hB);
        repeat (3) begin
            check("t5_no_issue", int'(issue_transmit), 0);
            tick();
        end

        // FU busy blocks issue; holdoff then busy gate the second op.
        fu_busy = 1'b1;
        set_disp(8'h20, 2'b11, 4'h0, 4'h0, 8'h21, 8'h22, 4'h4);
        tick();
        set_disp(8'h21, 2'b11, 4'h0, 4'h0, 8'h31, 8'h32, 4'h5);
        tick();
        repeat (10) begin
            check("t6_busy_hold", int'(issue_transmit), 0);
            tick();
        end
        fu_busy = 1'b0;
        tick();
        check("t6_tx_first", int'(issue_transmit), 1);
        check("t6_rob_first", int'(issue_robid), 4);
        check("t6_dep_first", int'(issue_depvals[0]), 'h21);
        fu_busy = 1'b1;
        tick();
        repeat (3) begin
            check("t6_busy_again", int'(issue_transmit), 0);
            tick();
        end
        fu_busy = 1'b0;
        tick();
        check("t6_tx_second", int'(issue_transmit), 1);
        check("t6_rob_second", int'(issue_robid), 5);
        tick();

        // Asynchronous reset in the middle of a wakeup.
        set_disp(8'h30, 2'b10, 4'h3, 4'h0, 8'h00, 8'h44, 4'h6);
        tick();
        set_cdb(4'h3, 8'h77);
        #2 rst = 1'b0;
        #1;
        check("t7_async_tx", int'(issue_transmit), 0);
        check("t7_async_occ", int'(occupancy), 0);
        check("t7_async_ready", int'(dispatch_ready), 1);
        check("t7_async_rob", int'(issue_robid), 0);
        check("t7_async_dep1", int'(issue_depvals[1]), 0);
        check("t7_async_op", int'(issue_operand), 0);
        tick();
        rst = 1'b1;
        tick();
        set_disp(8'h40, 2'b11, 4'h0, 4'h0, 8'h41, 8'h42, 4'h7);
        tick();
        tick();
        check("t7_post_tx", int'(issue_transmit), 1);
        check("t7_post_rob", int'(issue_robid), 7);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
